operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Decode-side read end of the register-file interface. The write-back stage drives its write port; this block is the reader.
- Holds the 32x32 integer register file with x0 hardwired to zero.
- Resolves rs1/rs2 for the instruction in ID, using write-back bypass and EX/MEM forwarding.
- Detects load-use hazards and raises a one-cycle stall.
- Registers the resolved operands into the ID/EX boundary.

Parameters:
- XLEN, 32, data width of registers and operands.
- AW, 5, register address width (fixed at 32 registers).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- wb_en  in  1  write-back write enable (reg_write of the WB-stage instruction).
- wb_rd  in  AW  write-back destination register.
- wb_data  in  XLEN  write-back data (selected result: ALU, load, PC+4 or U-immediate).
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  AW  source register indices.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2.
- ex_reg_write, ex_load  in  1  EX-stage instruction writes rd / is a load.
- ex_rd  in  AW  EX-stage destination.
- ex_result  in  XLEN  EX ALU result (valid when not a load).
- mem_reg_write  in  1  MEM-stage instruction writes rd.
- mem_rd  in  AW  MEM-stage destination.
- mem_result  in  XLEN  MEM forwarding data (ALU result or aligned load data).
- hold  in  1  global pipeline freeze.
- flush  in  1  kill the ID instruction (taken branch/jump).
- stall  out  1  load-use stall request to PC/IF/ID.
- ex_valid_q  out  1  registered valid into EX.
- rs1_data_q, rs2_data_q  out  XLEN  registered operands into EX.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst_n=0):
  - all 32 registers = 0.
  - ex_valid_q = 0, rs1_data_q = rs2_data_q = 0, stall_cnt = 0.
  - stall reads 0 because it is gated by id_valid, which is 0 during reset.
  - Reset mid-operation discards any pending stall or operands.
- Regfile write: on a clock edge when wb_en=1 and wb_rd!=0. Writes to x0 are dropped. Writes occur independently of hold, stall and flush; the caller gates wb_en.
- Operand resolution is combinational per source s, first match wins:
  1. s==0 gives 0.
  2. ex_reg_write and ex_rd==s and !ex_load gives ex_result.
  3. mem_reg_write and mem_rd==s gives mem_result.
  4. wb_en and wb_rd==s gives wb_data (same-cycle write-through).
  5. Otherwise the regfile value.
- stall = id_valid & !flush & ex_reg_write & ex_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Asserted for exactly one cycle per load-use pair. On the next cycle the load is in MEM and the value is forwarded from mem_result.
- ID/EX register update, priority flush > hold > stall > normal:
  - flush: ex_valid_q <= 0; operands unchanged.
  - hold (no flush): all outputs keep their value.
  - stall: ex_valid_q <= 0 (bubble); operands unchanged.
  - normal: ex_valid_q <= id_valid; rs1/rs2_data_q <= resolved values.
- Unused sources (id_use_*=0) are still resolved and registered, but never cause a stall.
- stall_cnt increments on each edge where stall=1 and hold=0. It saturates at all-ones.
- Latency: ID to EX operands is one cycle. WB data is visible to the ID read in the same cycle it is written.

Decomposition:
- Shared package rv32i_pkg holds:
  - XLEN, AW, REG_X0 = 5'd0.
  - Forward-select enum: FWD_RF, FWD_WB, FWD_MEM, FWD_EX, FWD_ZERO.
- One sub-module, reg_file_2r1w: 32xXLEN, async-reset, two combinational read ports, one write port, x0 forced to zero.
- Forwarding, stall logic and ID/EX registers stay in operand_fetch.

Test Plan:
1. Write x5=0xDEADBEEF via wb_en; two cycles later read rs1=5 with no hazards -> rs1_data_q=0xDEADBEEF, ex_valid_q=1.
2. Same cycle: wb writes x7=0x11, ex writes x7 with ex_result=0x22, mem writes x7 with mem_result=0x33; read rs2=7 -> rs2_data_q=0x22. Drop the EX match -> 0x33. Drop MEM too -> 0x11.
3. Load-use: ex_load=1, ex_rd=3, id_rs1=3, id_use_rs1=1 -> stall=1 for one cycle, ex_valid_q=0. Next cycle mem_rd=3, mem_result=0x44 -> stall=0, rs1_data_q=0x44, stall_cnt=1.
4. wb_en=1, wb_rd=0, wb_data=0xFFFFFFFF; ex_rd=0 load with id_rs1=0 -> no stall, rs1_data_q=0.
5. Load-use condition with flush=1 -> stall=0, ex_valid_q=0. Same condition with hold=1 -> outputs frozen, stall_cnt unchanged.
6. Assert rst_n=0 during a stall cycle -> all outputs and registers read 0 immediately. After release, reading x5 returns 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: register-file geometry and the
// operand forward-select encoding used by the decode-side operand fetch.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_X0 = 5'd0;

  // Where a source operand is taken from, in decreasing priority order
  // FWD_ZERO > FWD_EX > FWD_MEM > FWD_WB > FWD_RF.
  typedef enum logic [2:0] {
    FWD_RF   = 3'd0,
    FWD_WB   = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_EX   = 3'd3,
    FWD_ZERO = 3'd4
  } fwd_sel_e;

  // Pick the youngest in-flight producer of src. A load in EX has no data yet,
  // so it is skipped here; the stall logic covers that case.
  function automatic fwd_sel_e fwd_select(
    input logic [AW-1:0] src,
    input logic          ex_reg_write,
    input logic          ex_load,
    input logic [AW-1:0] ex_rd,
    input logic          mem_reg_write,
    input logic [AW-1:0] mem_rd,
    input logic          wb_en,
    input logic [AW-1:0] wb_rd
  );
    fwd_sel_e sel;
    if (src == REG_X0) begin
      sel = FWD_ZERO;
    end else if (ex_reg_write && !ex_load && (ex_rd == src)) begin
      sel = FWD_EX;
    end else if (mem_reg_write && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_en && (wb_rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// 32 x XLEN integer register file: two combinational read ports, one write
// port, asynchronous reset, x0 reads as zero and ignores writes.
module reg_file_2r1w #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_b
);
  import rv32i_pkg::*;

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] regs_q [0:NREG-1];
  logic [XLEN-1:0] regs_d [0:NREG-1];

  // Next-state of the array: apply the single write, dropping writes to x0.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != REG_X0)) begin
      regs_d[waddr] = wdata;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register array state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports; x0 is forced to zero regardless of array contents.
  always_comb begin
    if (raddr_a == REG_X0) begin
      rdata_a = {XLEN{1'b0}};
    end else begin
      rdata_a = regs_q[raddr_a];
    end
    if (raddr_b == REG_X0) begin
      rdata_b = {XLEN{1'b0}};
    end else begin
      rdata_b = regs_q[raddr_b];
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode-side operand fetch: register file read, EX/MEM/WB forwarding,
// load-use stall detection and the ID/EX operand registers.
module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_reg_write,
  input  logic             ex_load,
  input  logic [AW-1:0]    ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_reg_write,
  input  logic [AW-1:0]    mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             hold,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid_q,
  output logic [XLEN-1:0]  rs1_data_q,
  output logic [XLEN-1:0]  rs2_data_q,
  output logic [CNT_W-1:0] stall_cnt
);
  import rv32i_pkg::*;

  logic [XLEN-1:0]  rf_rs1_s;
  logic [XLEN-1:0]  rf_rs2_s;
  fwd_sel_e         sel_rs1_s;
  fwd_sel_e         sel_rs2_s;
  logic [XLEN-1:0]  rs1_res_s;
  logic [XLEN-1:0]  rs2_res_s;
  logic             stall_s;
  logic             ex_valid_d;
  logic [XLEN-1:0]  rs1_data_d;
  logic [XLEN-1:0]  rs2_data_d;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  reg_file_2r1w #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (id_rs1),
    .rdata_a (rf_rs1_s),
    .raddr_b (id_rs2),
    .rdata_b (rf_rs2_s)
  );

  // Operand mux driven by a forward-select code.
  function automatic logic [XLEN-1:0] fwd_mux(
    input fwd_sel_e        sel,
    input logic [XLEN-1:0] rf_val,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] mem_val,
    input logic [XLEN-1:0] ex_val
  );
    logic [XLEN-1:0] val;
    case (sel)
      FWD_ZERO: val = {XLEN{1'b0}};
      FWD_EX:   val = ex_val;
      FWD_MEM:  val = mem_val;
      FWD_WB:   val = wb_val;
      FWD_RF:   val = rf_val;
      default:  val = {XLEN{1'b0}};
    endcase
    return val;
  endfunction

  // Resolve both sources; WB write-through makes same-cycle writes visible.
  always_comb begin
    sel_rs1_s = fwd_select(id_rs1, ex_reg_write, ex_load, ex_rd,
                           mem_reg_write, mem_rd, wb_en, wb_rd);
    sel_rs2_s = fwd_select(id_rs2, ex_reg_write, ex_load, ex_rd,
                           mem_reg_write, mem_rd, wb_en, wb_rd);
    rs1_res_s = fwd_mux(sel_rs1_s, rf_rs1_s, wb_data, mem_result, ex_result);
    rs2_res_s = fwd_mux(sel_rs2_s, rf_rs2_s, wb_data, mem_result, ex_result);
  end

  // Load-use hazard: a load in EX feeds a source actually read by ID.
  always_comb begin
    stall_s = id_valid & ~flush & ex_reg_write & ex_load & (ex_rd != REG_X0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  assign stall     = stall_s;
  assign stall_cnt = stall_cnt_q;

  // ID/EX next state, priority flush > hold > stall > normal advance.
  always_comb begin
    ex_valid_d = ex_valid_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (hold) begin
      ex_valid_d = ex_valid_q;
    end else if (stall_s) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = id_valid;
      rs1_data_d = rs1_res_s;
      rs2_data_d = rs2_res_s;
    end
  end

  // Saturating count of stall cycles that actually took effect (not held).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && !hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // ID/EX boundary registers and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      rs1_data_q  <= {XLEN{1'b0}};
      rs2_data_q  <= {XLEN{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q  <= ex_valid_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table, a reset
// sequence during a stall, then random traffic against a reference model.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_reg_write, ex_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        hold, flush;
  logic        stall;
  logic        ex_valid_q;
  logic [31:0] rs1_data_q, rs2_data_q;
  logic [15:0] stall_cnt;

  operand_fetch #(.XLEN(32), .AW(5), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_reg_write  (ex_reg_write),
    .ex_load       (ex_load),
    .ex_rd         (ex_rd),
    .ex_result     (ex_result),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .hold          (hold),
    .flush         (flush),
    .stall         (stall),
    .ex_valid_q    (ex_valid_q),
    .rs1_data_q    (rs1_data_q),
    .rs2_data_q    (rs2_data_q),
    .stall_cnt     (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wb_en;   logic [4:0] wb_rd;  logic [31:0] wb_data;
    logic        id_valid; logic [4:0] rs1;   logic [4:0]  rs2;
    logic        use1;    logic use2;
    logic        ex_rw;   logic ex_ld;        logic [4:0]  ex_rd;  logic [31:0] ex_res;
    logic        mem_rw;  logic [4:0] mem_rd; logic [31:0] mem_res;
    logic        hold;    logic flush;
    logic        e_stall; logic e_valid;
    logic [31:0] e_rs1;   logic [31:0] e_rs2; logic [15:0] e_cnt;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_rf [0:31];
  logic        m_valid;
  logic [31:0] m_rs1, m_rs2;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
    if (ex_reg_write && !ex_load && ex_rd == s) return ex_result;
    if (mem_reg_write && mem_rd == s) return mem_result;
    if (wb_en && wb_rd == s) return wb_data;
    return m_rf[s];
  endfunction

  function automatic logic m_stall();
    logic needs;
    needs = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
    return id_valid && !flush && ex_reg_write && ex_load && ex_rd != 5'd0 && needs;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_valid = 1'b0; m_rs1 = 32'd0; m_rs2 = 32'd0; m_cnt = 0;
  endtask

  task automatic drive(input vec_t v);
    wb_en = v.wb_en; wb_rd = v.wb_rd; wb_data = v.wb_data;
    id_valid = v.id_valid; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_use_rs1 = v.use1; id_use_rs2 = v.use2;
    ex_reg_write = v.ex_rw; ex_load = v.ex_ld; ex_rd = v.ex_rd; ex_result = v.ex_res;
    mem_reg_write = v.mem_rw; mem_rd = v.mem_rd; mem_result = v.mem_res;
    hold = v.hold; flush = v.flush;
  endtask

  // One clock with current inputs; checks against table entry or model.
  task automatic run_cycle(input bit from_tbl, input vec_t v, input string tag);
    logic [31:0] r1, r2;
    logic        st;
    #1;
    r1 = m_read(id_rs1);
    r2 = m_read(id_rs2);
    st = m_stall();
    chk({tag, ".stall"}, {31'd0, stall}, from_tbl ? {31'd0, v.e_stall} : {31'd0, st});
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (hold) m_valid = m_valid;
    else if (st) m_valid = 1'b0;
    else begin m_valid = id_valid; m_rs1 = r1; m_rs2 = r2; end
    if (st && !hold && m_cnt < 65535) m_cnt++;
    if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
    #1;
    if (from_tbl) begin
      chk({tag, ".ex_valid_q"}, {31'd0, ex_valid_q}, {31'd0, v.e_valid});
      chk({tag, ".rs1_data_q"}, rs1_data_q, v.e_rs1);
      chk({tag, ".rs2_data_q"}, rs2_data_q, v.e_rs2);
      chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, v.e_cnt});
    end else begin
      chk({tag, ".ex_valid_q"}, {31'd0, ex_valid_q}, {31'd0, m_valid});
      chk({tag, ".rs1_data_q"}, rs1_data_q, m_rs1);
      chk({tag, ".rs2_data_q"}, rs2_data_q, m_rs2);
      chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, m_cnt[31:0]);
    end
  endtask

  vec_t tbl [16];
  vec_t v;
  vec_t zero_v;

  initial begin
    // wb_en rd data | idv rs1 rs2 u1 u2 | exw exl exrd exres | mw mrd mres | hold flush | st val rs1 rs2 cnt
    tbl[0]  = '{1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,5'd0,1'b0,1'b0, 1'b0,1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0, 1'b0,1'b0,32'h0,32'h0,16'd0};
    tbl[1]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,5'd0,1'b0,1'b0, 1'b0,1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0, 1'b0,1'b0,32'h0,32'h0,16'd0};
    tbl[2]  = '{1'b0,5'd0,32'h0,        1'b1,5'd5,5'd0,1'b1,1'b0, 1'b0,1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0, 1'b0,1'b1,32'hDEADBEEF,32'h0,16'd0};
    tbl[3]  = '{1'b1,5'd7,32'h11,       1'b1,5'd5,5'd7,1'b1,1'b1, 1'b1,1'b0,5'd7,32'h22, 1'b1,5'd7,32'h33, 1'b0,1'b0, 1'b0,1'b1,32'hDEADBEEF,32'h22,16'd0};
    tbl[4]  = '{1'b1,5'd7,32'h11,       1'b1,5'd5,5'd7,1'b1,1'b1, 1'b0,1'b0,5'd7,32'h22, 1'b1,5'd7,32'h33, 1'b0,1'b0, 1'b0,1'b1,32'hDEADBEEF,32'h33,16'd0};
    tbl[5]  = '{1'b1,5'd7,32'h11,       1'b1,5'd5,5'd7,1'b1,1'b1, 1'b0,1'b0,5'd7,32'h22, 1'b0,5'd7,32'h33, 1'b0,1'b0, 1'b0,1'b1,32'hDEADBEEF,32'h11,16'd0};
    tbl[6]  = '{1'b1,5'd7,32'h55,       1'b1,5'd5,5'd7,1'b1,1'b1, 1'b0,1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0, 1'b0,1'b1,32'hDEADBEEF,32'h55,16'd0};
    tbl[7]  = '{1'b0,5'd0,32'h0,        1'b1,5'd3,5'd0,1'b1,1'b0, 1'b1,1'b1,5'd3,32'h99, 1'b0,5'd0,32'h0, 1'b0,1'b0, 1'b1,1'b0,32'hDEADBEEF,32'h55,16'd1};
    tbl[8]  = '{1'b0,5'd0,32'h0,        1'b1,5'd3,5'd0,1'b1,1'b0, 1'b0,1'b0,5'd0,32'h0, 1'b1,5'd3,32'h44, 1'b0,1'b0, 1'b0,1'b1,32'h44,32'h0,16'd1};
    tbl[9]  = '{1'b1,5'd0,32'hFFFFFFFF, 1'b1,5'd0,5'd0,1'b1,1'b0, 1'b1,1'b1,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0, 1'b0,1'b1,32'h0,32'h0,16'd1};
    tbl[10] = '{1'b0,5'd0,32'h0,        1'b1,5'd0,5'd0,1'b1,1'b0, 1'b0,1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0, 1'b0,1'b1,32'h0,32'h0,16'd1};
    tbl[11] = '{1'b0,5'd0,32'h0,        1'b1,5'd3,5'd5,1'b1,1'b0, 1'b1,1'b1,5'd3,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,32'h0,16'd1};
    tbl[12] = '{1'b0,5'd0,32'h0,        1'b1,5'd5,5'd7,1'b1,1'b1, 1'b0,1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0, 1'b0,1'b1,32'hDEADBEEF,32'h55,16'd1};
    tbl[13] = '{1'b0,5'd0,32'h0,        1'b1,5'd3,5'd0,1'b1,1'b0, 1'b1,1'b1,5'd3,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b0, 1'b1,1'b1,32'hDEADBEEF,32'h55,16'd1};
    tbl[14] = '{1'b0,5'd0,32'h0,        1'b1,5'd5,5'd3,1'b1,1'b0, 1'b1,1'b1,5'd3,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0, 1'b0,1'b1,32'hDEADBEEF,32'h0,16'd1};
    tbl[15] = '{1'b0,5'd0,32'h0,        1'b0,5'd3,5'd7,1'b1,1'b1, 1'b1,1'b1,5'd3,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0, 1'b0,1'b0,32'h0,32'h55,16'd1};
    zero_v = tbl[1];

    // Reset
    rst_n = 1'b0;
    drive(zero_v);
    m_reset();
    #12;
    chk("rst.ex_valid_q", {31'd0, ex_valid_q}, 32'd0);
    chk("rst.rs1_data_q", rs1_data_q, 32'd0);
    chk("rst.rs2_data_q", rs2_data_q, 32'd0);
    chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      run_cycle(1'b1, tbl[i], $sformatf("tbl%0d", i));
    end

    // Async reset in the middle of a load-use stall cycle
    v = tbl[7];
    drive(v);
    #1;
    chk("rstmid.pre_stall", {31'd0, stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    id_valid = 1'b0;
    #1;
    chk("rstmid.ex_valid_q", {31'd0, ex_valid_q}, 32'd0);
    chk("rstmid.rs1_data_q", rs1_data_q, 32'd0);
    chk("rstmid.rs2_data_q", rs2_data_q, 32'd0);
    chk("rstmid.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rstmid.stall", {31'd0, stall}, 32'd0);
    m_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = zero_v;
    v.id_valid = 1'b1; v.rs1 = 5'd5; v.rs2 = 5'd7; v.use1 = 1'b1; v.use2 = 1'b1;
    drive(v);
    run_cycle(1'b0, v, "post_rst_x5");
    chk("post_rst_x5.direct", rs1_data_q, 32'd0);

    // Randomized traffic against the model, small index range for collisions
    for (int n = 0; n < 400; n++) begin
      wb_en         = 1'($urandom_range(0, 1));
      wb_rd         = 5'($urandom_range(0, 7));
      wb_data       = $urandom;
      id_valid      = ($urandom_range(0, 7) != 0);
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_use_rs1    = 1'($urandom_range(0, 1));
      id_use_rs2    = 1'($urandom_range(0, 1));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_load       = 1'($urandom_range(0, 1));
      ex_rd         = 5'($urandom_range(0, 7));
      ex_result     = $urandom;
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_rd        = 5'($urandom_range(0, 7));
      mem_result    = $urandom;
      hold          = ($urandom_range(0, 7) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      run_cycle(1'b0, zero_v, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
